// File: rtl/operand_fetch_stage_if.sv
// Bus between the operand fetch stage and its neighbours: IF/ID latch, register file,
// EX/MEM forwarding sources and the ID/EX pipeline register outputs.
interface operand_fetch_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             flush;
    logic             hold;
    logic [4:0]       rf_rn1;
    logic [4:0]       rf_rn2;
    logic [XLEN-1:0]  rf_out1;
    logic [XLEN-1:0]  rf_out2;
    logic [XLEN-1:0]  ex_result;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [XLEN-1:0]  mem_result;
    logic             stall_out;
    logic             idex_valid;
    logic [31:0]      idex_instr;
    logic [XLEN-1:0]  idex_pc;
    logic [XLEN-1:0]  idex_rs1val;
    logic [XLEN-1:0]  idex_rs2val;
    logic [4:0]       idex_rd;
    logic             idex_regwrite;
    logic             idex_memread;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output if_valid, if_instr, if_pc, flush, hold, rf_out1, rf_out2, ex_result,
               mem_rd, mem_regwrite, mem_result,
        input  rf_rn1, rf_rn2, stall_out, idex_valid, idex_instr, idex_pc, idex_rs1val,
               idex_rs2val, idex_rd, idex_regwrite, idex_memread, stall_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, hold, rf_out1, rf_out2, ex_result,
               mem_rd, mem_regwrite, mem_result,
        output rf_rn1, rf_rn2, stall_out, idex_valid, idex_instr, idex_pc, idex_rs1val,
               idex_rs2val, idex_rd, idex_regwrite, idex_memread, stall_cnt
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-side operand stage: register file addressing, EX/MEM forwarding, load-use
// bubble insertion and the ID/EX pipeline register.
module operand_fetch_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    operand_fetch_stage_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd_dec;
    logic            regwrite, memread, uses_rs1, uses_rs2;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            load_use, stall;

    logic             idex_valid_q, idex_valid_d;
    logic [31:0]      idex_instr_q, idex_instr_d;
    logic [XLEN-1:0]  idex_pc_q, idex_pc_d;
    logic [XLEN-1:0]  idex_rs1val_q, idex_rs1val_d;
    logic [XLEN-1:0]  idex_rs2val_q, idex_rs2val_d;
    logic [4:0]       idex_rd_q, idex_rd_d;
    logic             idex_regwrite_q, idex_regwrite_d;
    logic             idex_memread_q, idex_memread_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        opcode   = bus.if_instr[6:0];
        rs1      = bus.if_instr[19:15];
        rs2      = bus.if_instr[24:20];
        regwrite = 1'b0;
        memread  = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal: begin
                regwrite = 1'b1;
                uses_rs1 = 1'b0;
            end
            OpJalr, OpImm: regwrite = 1'b1;
            OpLoad: begin
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            OpReg: begin
                regwrite = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpStore, OpBranch: uses_rs2 = 1'b1;
            default: ;
        endcase
        rd_dec = regwrite ? bus.if_instr[11:7] : 5'd0;
    end

    // A load in ID/EX has no result yet, so it is never an EX forwarding source.
    always_comb begin
        ex_hit1  = uses_rs1 && (rs1 != 5'd0) && idex_valid_q && idex_regwrite_q &&
                   !idex_memread_q && (idex_rd_q == rs1);
        ex_hit2  = uses_rs2 && (rs2 != 5'd0) && idex_valid_q && idex_regwrite_q &&
                   !idex_memread_q && (idex_rd_q == rs2);
        mem_hit1 = uses_rs1 && (rs1 != 5'd0) && bus.mem_regwrite && (bus.mem_rd == rs1);
        mem_hit2 = uses_rs2 && (rs2 != 5'd0) && bus.mem_regwrite && (bus.mem_rd == rs2);
        rs1_val  = ex_hit1 ? bus.ex_result : (mem_hit1 ? bus.mem_result : bus.rf_out1);
        rs2_val  = ex_hit2 ? bus.ex_result : (mem_hit2 ? bus.mem_result : bus.rf_out2);
        load_use = bus.if_valid && idex_valid_q && idex_memread_q && (idex_rd_q != 5'd0) &&
                   ((uses_rs1 && (rs1 == idex_rd_q)) || (uses_rs2 && (rs2 == idex_rd_q)));
        stall    = (load_use || bus.hold) && !bus.flush;
    end

    always_comb begin
        idex_valid_d    = idex_valid_q;
        idex_instr_d    = idex_instr_q;
        idex_pc_d       = idex_pc_q;
        idex_rs1val_d   = idex_rs1val_q;
        idex_rs2val_d   = idex_rs2val_q;
        idex_rd_d       = idex_rd_q;
        idex_regwrite_d = idex_regwrite_q;
        idex_memread_d  = idex_memread_q;
        stall_cnt_d     = stall_cnt_q;

        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (bus.flush || (load_use && !bus.hold)) begin
            idex_valid_d    = 1'b0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
            idex_rd_d       = 5'd0;
        end else if (!bus.hold) begin
            idex_valid_d    = bus.if_valid;
            idex_instr_d    = bus.if_instr;
            idex_pc_d       = bus.if_pc;
            idex_rs1val_d   = rs1_val;
            idex_rs2val_d   = rs2_val;
            idex_rd_d       = bus.if_valid ? rd_dec : 5'd0;
            idex_regwrite_d = bus.if_valid && regwrite;
            idex_memread_d  = bus.if_valid && memread;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_q    <= 1'b0;
            idex_instr_q    <= '0;
            idex_pc_q       <= '0;
            idex_rs1val_q   <= '0;
            idex_rs2val_q   <= '0;
            idex_rd_q       <= 5'd0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            idex_valid_q    <= idex_valid_d;
            idex_instr_q    <= idex_instr_d;
            idex_pc_q       <= idex_pc_d;
            idex_rs1val_q   <= idex_rs1val_d;
            idex_rs2val_q   <= idex_rs2val_d;
            idex_rd_q       <= idex_rd_d;
            idex_regwrite_q <= idex_regwrite_d;
            idex_memread_q  <= idex_memread_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign bus.rf_rn1        = rs1;
    assign bus.rf_rn2        = rs2;
    assign bus.stall_out     = stall;
    assign bus.idex_valid    = idex_valid_q;
    assign bus.idex_instr    = idex_instr_q;
    assign bus.idex_pc       = idex_pc_q;
    assign bus.idex_rs1val   = idex_rs1val_q;
    assign bus.idex_rs2val   = idex_rs2val_q;
    assign bus.idex_rd       = idex_rd_q;
    assign bus.idex_regwrite = idex_regwrite_q;
    assign bus.idex_memread  = idex_memread_q;
    assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed hazard scenarios plus a randomized run
// compared against a pipeline-level reference model.
module tb_operand_fetch_stage;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LOAD = 7'b0000011, OPIMM = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011, STORE = 7'b0100011, BRANCH = 7'b1100011;
    localparam logic [6:0] FENCE = 7'b0001111;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } idex_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    operand_fetch_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    operand_fetch_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, OPR};
    endfunction

    function automatic bit writes_rd(logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OPR};
    endfunction

    function automatic bit reads_rs1(logic [6:0] op);
        return !(op inside {LUI, AUIPC, JAL});
    endfunction

    function automatic bit reads_rs2(logic [6:0] op);
        return op inside {STORE, BRANCH, OPR};
    endfunction

    // Youngest producer wins; a load still in ID/EX cannot supply its value.
    function automatic logic [31:0] operand(idex_t m, logic [4:0] rs, bit used,
                                            logic [31:0] rfv, logic [31:0] ex,
                                            logic [31:0] memv, logic [4:0] mrd, bit mrw);
        if (!used || rs == 5'd0) return rfv;
        if (m.valid && m.rw && !m.mr && m.rd == rs) return ex;
        if (mrw && mrd == rs) return memv;
        return rfv;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OPR, STORE, BRANCH, FENCE};
        logic [31:0] x;
        x        = $urandom;
        x[6:0]   = ops[$urandom_range(9)];
        x[11:7]  = 5'($urandom_range(7));
        x[19:15] = 5'($urandom_range(7));
        x[24:20] = 5'($urandom_range(7));
        return x;
    endfunction

    task automatic set_idle();
        bus.if_valid     = 1'b0;
        bus.if_instr     = '0;
        bus.if_pc        = '0;
        bus.flush        = 1'b0;
        bus.hold         = 1'b0;
        bus.rf_out1      = '0;
        bus.rf_out2      = '0;
        bus.ex_result    = '0;
        bus.mem_rd       = '0;
        bus.mem_regwrite = 1'b0;
        bus.mem_result   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_r(5'd1, 5'd2, 5'd3);
        bus.rf_out1  = 32'h1234;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.if_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.idex_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %0d expected 0", bus.idex_valid);
        end
        n_tests++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_out);
        end
        n_tests++;
        if (bus.stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt);
        end
        n_tests++;
        if (bus.idex_rs1val !== 32'h0) begin
            n_fail++; $display("FAIL reset_rs1val: got %h expected 0", bus.idex_rs1val);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_forward();
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd5, OPIMM);
        bus.if_pc    = 32'h100;
        step();
        n_tests++;
        if (bus.idex_rd !== 5'd5 || bus.idex_regwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_addi_rd: got rd=%0d rw=%0d expected rd=5 rw=1",
                     bus.idex_rd, bus.idex_regwrite);
        end
        bus.if_instr  = enc_r(5'd5, 5'd5, 5'd6);
        bus.if_pc     = 32'h104;
        bus.ex_result = 32'd7;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL alu_no_stall: got %0d expected 0", bus.stall_out);
        end
        step();
        n_tests++;
        if (bus.idex_rs1val !== 32'd7 || bus.idex_rs2val !== 32'd7 || bus.idex_rd !== 5'd6) begin
            n_fail++;
            $display("FAIL alu_fwd: got rs1=%h rs2=%h rd=%0d expected 7 7 6",
                     bus.idex_rs1val, bus.idex_rs2val, bus.idex_rd);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_i(12'd0, 5'd1, 3'd2, 5'd7, LOAD);
        bus.rf_out1  = 32'd100;
        step();
        n_tests++;
        if (bus.idex_memread !== 1'b1 || bus.idex_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL lu_load: got mr=%0d rd=%0d expected 1 7", bus.idex_memread, bus.idex_rd);
        end
        bus.if_instr  = enc_r(5'd2, 5'd7, 5'd8);
        bus.rf_out1   = 32'h111;
        bus.rf_out2   = 32'h22;
        bus.ex_result = 32'd104;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %0d expected 1", bus.stall_out);
        end
        step();
        n_tests++;
        if (bus.idex_valid !== 1'b0 || bus.idex_rd !== 5'd0 || bus.idex_regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%0d rd=%0d rw=%0d expected 0 0 0",
                     bus.idex_valid, bus.idex_rd, bus.idex_regwrite);
        end
        bus.mem_rd       = 5'd7;
        bus.mem_regwrite = 1'b1;
        bus.mem_result   = 32'hDEADBEEF;
        bus.ex_result    = 32'h0;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL lu_release: got %0d expected 0", bus.stall_out);
        end
        step();
        n_tests++;
        if (bus.idex_rs1val !== 32'hDEADBEEF || bus.idex_rs2val !== 32'h22 ||
            bus.idex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_fwd: got rs1=%h rs2=%h v=%0d expected deadbeef 22 1",
                     bus.idex_rs1val, bus.idex_rs2val, bus.idex_valid);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lu_cnt: got %0d expected 1", bus.stall_cnt);
        end
    endtask

    task automatic test_x0_guard();
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_i(12'd0, 5'd1, 3'd2, 5'd0, LOAD);
        step();
        bus.if_instr     = enc_r(5'd0, 5'd0, 5'd1);
        bus.mem_rd       = 5'd0;
        bus.mem_regwrite = 1'b1;
        bus.mem_result   = 32'd5;
        bus.ex_result    = 32'h33;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL x0_stall: got %0d expected 0", bus.stall_out);
        end
        step();
        n_tests++;
        if (bus.idex_rs1val !== 32'h0 || bus.idex_rs2val !== 32'h0 || bus.idex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_vals: got rs1=%h rs2=%h v=%0d expected 0 0 1",
                     bus.idex_rs1val, bus.idex_rs2val, bus.idex_valid);
        end
    endtask

    task automatic test_flush_vs_stall();
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_i(12'd0, 5'd1, 3'd2, 5'd7, LOAD);
        step();
        bus.if_instr = enc_r(5'd2, 5'd7, 5'd8);
        bus.flush    = 1'b1;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %0d expected 0", bus.stall_out);
        end
        step();
        bus.flush = 1'b0;
        n_tests++;
        if (bus.idex_valid !== 1'b0 || bus.idex_regwrite !== 1'b0 || bus.idex_memread !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble: got v=%0d rw=%0d mr=%0d expected 0 0 0",
                     bus.idex_valid, bus.idex_regwrite, bus.idex_memread);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL flush_cnt: got %0d expected 0", bus.stall_cnt);
        end
    endtask

    task automatic test_hold();
        logic [31:0] addi;
        addi = enc_i(12'd7, 5'd0, 3'd0, 5'd5, OPIMM);
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = addi;
        bus.if_pc    = 32'h200;
        step();
        bus.hold     = 1'b1;
        bus.if_instr = enc_r(5'd0, 5'd3, 5'd6);
        bus.if_pc    = 32'h204;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (bus.stall_out !== 1'b1) begin
                n_fail++; $display("FAIL hold_stall%0d: got %0d expected 1", k, bus.stall_out);
            end
            step();
        end
        n_tests++;
        if (bus.idex_instr !== addi || bus.idex_pc !== 32'h200 || bus.idex_rd !== 5'd5 ||
            bus.idex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_keep: got instr=%h pc=%h rd=%0d v=%0d expected %h 200 5 1",
                     bus.idex_instr, bus.idex_pc, bus.idex_rd, bus.idex_valid, addi);
        end
        n_tests++;
        if (bus.stall_cnt !== 4'd3) begin
            n_fail++; $display("FAIL hold_cnt: got %0d expected 3", bus.stall_cnt);
        end
        bus.hold         = 1'b0;
        bus.mem_rd       = 5'd3;
        bus.mem_regwrite = 1'b1;
        bus.mem_result   = 32'd9;
        bus.rf_out1      = 32'd4;
        step();
        n_tests++;
        if (bus.idex_rs1val !== 32'd9) begin
            n_fail++; $display("FAIL hold_memfwd: got %h expected 9", bus.idex_rs1val);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_instr = enc_i(12'd0, 5'd1, 3'd2, 5'd7, LOAD);
        step();
        bus.if_instr = enc_r(5'd2, 5'd7, 5'd8);
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b1) begin
            n_fail++; $display("FAIL rms_stall: got %0d expected 1", bus.stall_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.stall_out !== 1'b0 || bus.idex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rms_clear: got stall=%0d v=%0d expected 0 0",
                     bus.stall_out, bus.idex_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.hold = 1'b1;
        repeat (CNT_MAX + 5) step();
        bus.hold = 1'b0;
        n_tests++;
        if (bus.stall_cnt !== 4'(CNT_MAX)) begin
            n_fail++; $display("FAIL sat_cnt: got %0d expected %0d", bus.stall_cnt, CNT_MAX);
        end
    endtask

    task automatic test_random();
        idex_t       m, nx;
        int          cnt;
        logic [31:0] regs [32];
        logic [31:0] instr, pc;
        logic [6:0]  op;
        logic [4:0]  r1, r2;
        bit          ivalid, keep, lu, exp_stall, u1, u2;
        do_reset();
        m = '0; cnt = 0; keep = 1'b0; pc = 32'h1000; instr = '0; ivalid = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : $urandom;
        for (int i = 0; i < 800; i++) begin
            if (!keep) begin
                instr  = rand_instr();
                pc     = pc + 32'd4;
                ivalid = ($urandom_range(9) != 0);
            end
            regs[$urandom_range(1, 7)] = $urandom;
            bus.if_valid     = ivalid;
            bus.if_instr     = instr;
            bus.if_pc        = pc;
            bus.rf_out1      = regs[instr[19:15]];
            bus.rf_out2      = regs[instr[24:20]];
            bus.ex_result    = $urandom;
            bus.mem_rd       = 5'($urandom_range(7));
            bus.mem_regwrite = 1'($urandom_range(1));
            bus.mem_result   = $urandom;
            bus.flush        = ($urandom_range(11) == 0);
            bus.hold         = ($urandom_range(9) == 0);
            rst              = ($urandom_range(49) == 0);
            #1;
            op = instr[6:0]; r1 = instr[19:15]; r2 = instr[24:20];
            u1 = reads_rs1(op); u2 = reads_rs2(op);
            lu = ivalid && m.valid && m.mr && m.rd != 5'd0 &&
                 ((u1 && r1 == m.rd) || (u2 && r2 == m.rd));
            exp_stall = (lu || bus.hold) && !bus.flush;
            n_tests++;
            if (bus.stall_out !== exp_stall) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, bus.stall_out,
                                   exp_stall);
            end
            n_tests++;
            if (bus.rf_rn1 !== r1 || bus.rf_rn2 !== r2) begin
                n_fail++; $display("FAIL rnd_rn[%0d]: got %0d,%0d expected %0d,%0d", i,
                                   bus.rf_rn1, bus.rf_rn2, r1, r2);
            end
            nx = m;
            if (rst) begin
                nx = '0;
                cnt = 0;
            end else begin
                if (exp_stall) cnt = (cnt + 1 > CNT_MAX) ? CNT_MAX : cnt + 1;
                if (bus.flush || (!bus.hold && lu)) begin
                    nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.rd = 5'd0;
                end else if (!bus.hold) begin
                    nx.valid = ivalid;
                    nx.instr = instr;
                    nx.pc    = pc;
                    nx.rs1   = operand(m, r1, u1, bus.rf_out1, bus.ex_result, bus.mem_result,
                                       bus.mem_rd, bus.mem_regwrite);
                    nx.rs2   = operand(m, r2, u2, bus.rf_out2, bus.ex_result, bus.mem_result,
                                       bus.mem_rd, bus.mem_regwrite);
                    nx.rw    = ivalid && writes_rd(op);
                    nx.mr    = ivalid && (op == LOAD);
                    nx.rd    = nx.rw ? instr[11:7] : 5'd0;
                end
            end
            keep = exp_stall && !rst;
            step();
            m = nx;
            n_tests++;
            if (bus.idex_valid !== m.valid || bus.idex_rd !== m.rd ||
                bus.idex_regwrite !== m.rw || bus.idex_memread !== m.mr) begin
                n_fail++;
                $display("FAIL rnd_ctl[%0d]: got v%0d rd%0d rw%0d mr%0d expected v%0d rd%0d rw%0d mr%0d",
                         i, bus.idex_valid, bus.idex_rd, bus.idex_regwrite, bus.idex_memread,
                         m.valid, m.rd, m.rw, m.mr);
            end
            n_tests++;
            if (bus.idex_instr !== m.instr || bus.idex_pc !== m.pc) begin
                n_fail++; $display("FAIL rnd_ipc[%0d]: got %h/%h expected %h/%h", i,
                                   bus.idex_instr, bus.idex_pc, m.instr, m.pc);
            end
            n_tests++;
            if (bus.idex_rs1val !== m.rs1 || bus.idex_rs2val !== m.rs2) begin
                n_fail++; $display("FAIL rnd_ops[%0d]: got %h/%h expected %h/%h", i,
                                   bus.idex_rs1val, bus.idex_rs2val, m.rs1, m.rs2);
            end
            n_tests++;
            if (bus.stall_cnt !== 4'(cnt)) begin
                n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bus.stall_cnt, cnt);
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        set_idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0_guard();
        test_flush_vs_stall();
        test_hold();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side operand stage of the 5-stage RISC-V pipeline, sitting between the IF/ID latch and the execute stage.
- Drives the register file read addresses and selects operands from the register file or from EX/MEM forwarding.
- Detects load-use hazards and inserts one bubble; owns and drives the ID/EX pipeline register.
- Write-back results need no bypass here: the register file writes on negedge clk, so a WB write is readable later in the same cycle.

Parameters:
- XLEN, 32, data/PC width
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID latch holds a real instruction
- if_instr  in  32  instruction from IF/ID
- if_pc  in  XLEN  PC of if_instr
- flush  in  1  taken branch/jump resolved in EX; kill younger work
- hold  in  1  downstream backpressure; freeze ID/EX register
- rf_rn1  out  5  register file read address 1
- rf_rn2  out  5  register file read address 2
- rf_out1  in  XLEN  register file read data 1 (already 0 for x0)
- rf_out2  in  XLEN  register file read data 2
- ex_result  in  XLEN  ALU result of the instruction currently in ID/EX
- mem_rd  in  5  destination of the instruction in EX/MEM
- mem_regwrite  in  1  EX/MEM instruction writes mem_rd
- mem_result  in  XLEN  EX/MEM writeback value (load data for loads)
- stall_out  out  1  hold PC and IF/ID this cycle
- idex_valid  out  1  ID/EX holds a real instruction
- idex_instr  out  32  instruction in ID/EX
- idex_pc  out  XLEN  PC in ID/EX
- idex_rs1val  out  XLEN  resolved operand 1
- idex_rs2val  out  XLEN  resolved operand 2
- idex_rd  out  5  destination register (0 when no regwrite)
- idex_regwrite  out  1  writes rd
- idex_memread  out  1  is a load
- stall_cnt  out  CNT_W  cycles with stall_out=1, saturating

Behaviour:
- Decode from if_instr[6:0]:
  - regwrite for LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011; otherwise rd forced to 0.
  - memread only for LOAD.
  - uses_rs1 for all except LUI/AUIPC/JAL.
  - uses_rs2 for STORE 0100011, BRANCH 1100011, OP.
- rf_rn1 = if_instr[19:15], rf_rn2 = if_instr[24:20], combinational, always driven.
- Operand select, per source, when the source is used and nonzero, highest priority first:
  1. idex_valid && idex_regwrite && !idex_memread && idex_rd==rs → ex_result
  2. mem_regwrite && mem_rd==rs && mem_rd!=0 → mem_result
  3. otherwise rf_out.
- Load-use: idex_valid && idex_memread && idex_rd!=0 && (rs1 or rs2 used and equal to idex_rd) && if_valid → load_use=1.
- stall_out = (load_use || hold) && !flush, combinational.
- Posedge update, priority rst > flush > hold > load_use > normal:
  - rst: idex_valid=0, all idex_* = 0, stall_cnt=0.
  - flush: idex_valid=0, idex_regwrite=0, idex_memread=0, idex_rd=0. The IF/ID instruction is discarded (IF clears it).
  - hold: all idex_* retain their values.
  - load_use: insert a bubble (idex_valid/regwrite/memread=0, rd=0). IF/ID is held, so the next cycle re-evaluates with the load in MEM and forwards via mem_result.
  - normal: capture decoded fields and resolved operands; idex_valid=if_valid. When if_valid=0, regwrite/memread/rd are 0.
- stall_cnt increments by 1 each cycle stall_out=1 and sticks at all-ones; it is not cleared by flush.
- Single-cycle hazard latency: exactly one bubble per load-use; zero bubbles for ALU-to-ALU dependencies.
- Reset mid-stall: the next cycle has stall_out=0 and idex_valid=0.
- flush concurrent with hold or load_use: flush wins, bubble written.

Test Plan:
- Reset: rst=1 for 2 cycles → idex_valid=0, stall_out=0, stall_cnt=0, idex_rs1val=0.
- ALU forward: addi x5,x0,7 then add x6,x5,x5 back-to-back (ex_result=7) → add captured with rs1val=rs2val=7, no stall.
- Load-use: lw x7,0(x1) then add x8,x7,x2 → one cycle stall_out=1 with a bubble in ID/EX; next cycle mem_rd=7, mem_result=0xDEADBEEF → rs1val=0xDEADBEEF, stall_cnt=1.
- x0 guard: lw x0 then add x1,x0,x0 → no stall; rs1val=rs2val=0 even with mem_rd=0, mem_result=5.
- Flush vs stall: load-use condition plus flush=1 in the same cycle → stall_out=0, idex_valid=0 next cycle, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles → idex_* unchanged, stall_cnt +3; the EX/MEM forward is taken over RF when both match (mem_result=9, rf_out1=4 → 9).
